tap_controller: RTL and testbench

IEEE 1149.1-style TAP controller and instruction register for the boundary-scan chain. It decodes `tms` into the 16-state TAP FSM and holds the instruction register. It generates the shift/capture/update strobes consumed by the bypass and boundary-scan data registers, including `bp_shift` for the bypass stage, and multiplexes their serial outputs onto `tdo`. It sits directly upstream of the bypass register and drives its select.

---
 rtl/tap_controller.sv | 185 ++++++++++++++++++
 tb/tb_tap_controller.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tap_controller.sv
// tap_controller
// IEEE 1149.1-style TAP state machine and instruction register. Decodes tms
// into the 16-state TAP FSM, holds the instruction register, produces the
// DR shift/capture/update strobes and multiplexes the data registers onto tdo.
//
// Optional feature macro: TAP_IDCODE_EN
//    defined   -> 32-bit ID register present, reset/TLR instruction is IDCODE
//    undefined -> no ID register, 0010 decodes as BYPASS, default is BYPASS
//
// Parameters
//    IR_WIDTH   instruction register length (>= 2)
//    IDCODE_VAL device ID, bit 0 must be 1 (only used with TAP_IDCODE_EN)
// Ports
//    clk, rst          test clock, asynchronous active-high reset
//    tms, tdi          test mode select and serial data in
//    bypass_out        serial output of the bypass register
//    bsr_out           serial output of the boundary-scan register
//    state             current TAP state encoding
//    ir                active (updated) instruction
//    shift_dr, capture_dr, update_dr   DR strobes, decoded from state
//    bp_shift          shift_dr qualified by bypass selection
//    bsr_select        EXTEST or SAMPLE/PRELOAD active
//    mode              EXTEST active
//    tdo, tdo_en       serial data out and its enable
module tap_controller #(
   parameter int          IR_WIDTH   = 4,
   parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                tms,
   input  logic                tdi,
   input  logic                bypass_out,
   input  logic                bsr_out,
   output logic [3:0]          state,
   output logic [IR_WIDTH-1:0] ir,
   output logic                shift_dr,
   output logic                capture_dr,
   output logic                update_dr,
   output logic                bp_shift,
   output logic                bsr_select,
   output logic                mode,
   output logic                tdo,
   output logic                tdo_en
);

   localparam logic [3:0] TLR      = 4'hF;
   localparam logic [3:0] RTI      = 4'hC;
   localparam logic [3:0] SEL_DR   = 4'h7;
   localparam logic [3:0] CAP_DR   = 4'h6;
   localparam logic [3:0] SH_DR    = 4'h2;
   localparam logic [3:0] EX1_DR   = 4'h1;
   localparam logic [3:0] PAUSE_DR = 4'h3;
   localparam logic [3:0] EX2_DR   = 4'h0;
   localparam logic [3:0] UPD_DR   = 4'h5;
   localparam logic [3:0] SEL_IR   = 4'h4;
   localparam logic [3:0] CAP_IR   = 4'hE;
   localparam logic [3:0] SH_IR    = 4'hA;
   localparam logic [3:0] EX1_IR   = 4'h9;
   localparam logic [3:0] PAUSE_IR = 4'hB;
   localparam logic [3:0] EX2_IR   = 4'h8;
   localparam logic [3:0] UPD_IR   = 4'hD;

   localparam logic [IR_WIDTH-1:0] OP_EXTEST = '0;
   localparam logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(1);
   localparam logic [IR_WIDTH-1:0] OP_BYPASS = '1;
`ifdef TAP_IDCODE_EN
   localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(2);
   localparam logic [IR_WIDTH-1:0] DEFAULT_IR = OP_IDCODE;
`else
   localparam logic [IR_WIDTH-1:0] DEFAULT_IR = OP_BYPASS;
`endif

   logic [3:0]          next_state;
   logic [IR_WIDTH-1:0] ir_sr;
   logic                sel_extest;
   logic                sel_sample;
   logic                sel_idcode;
   logic                sel_bypass;
   logic                id_bit;

   // Standard 1149.1 next-state table; tms=1 always walks toward TLR, so five
   // consecutive ones reach TLR from any state.
   always_comb begin
      next_state = TLR;
      case (state)
         TLR:      next_state = tms ? TLR    : RTI;
         RTI:      next_state = tms ? SEL_DR : RTI;
         SEL_DR:   next_state = tms ? SEL_IR : CAP_DR;
         CAP_DR:   next_state = tms ? EX1_DR : SH_DR;
         SH_DR:    next_state = tms ? EX1_DR : SH_DR;
         EX1_DR:   next_state = tms ? UPD_DR : PAUSE_DR;
         PAUSE_DR: next_state = tms ? EX2_DR : PAUSE_DR;
         EX2_DR:   next_state = tms ? UPD_DR : SH_DR;
         UPD_DR:   next_state = tms ? SEL_DR : RTI;
         SEL_IR:   next_state = tms ? TLR    : CAP_IR;
         CAP_IR:   next_state = tms ? EX1_IR : SH_IR;
         SH_IR:    next_state = tms ? EX1_IR : SH_IR;
         EX1_IR:   next_state = tms ? UPD_IR : PAUSE_IR;
         PAUSE_IR: next_state = tms ? EX2_IR : PAUSE_IR;
         EX2_IR:   next_state = tms ? UPD_IR : SH_IR;
         UPD_IR:   next_state = tms ? SEL_DR : RTI;
         default:  next_state = TLR;
      endcase
   end

   // TAP state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= TLR;
      else     state <= next_state;
   end

   // Instruction shift register: captures 0..01 so the host can verify chain
   // integrity, then shifts right with tdi entering at the MSB. The edge that
   // leaves Shift-IR still shifts, so N clocks in Shift-IR shift N bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  ir_sr <= '0;
      else if (state == CAP_IR) ir_sr <= IR_WIDTH'(1);
      else if (state == SH_IR)  ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
   end

   // Active instruction only changes when leaving Update-IR, so a reset in
   // the middle of a shift leaves it untouched apart from the forced default.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  ir <= DEFAULT_IR;
      else if (state == TLR)    ir <= DEFAULT_IR;
      else if (state == UPD_IR) ir <= ir_sr;
   end

   // Instruction decode; every unassigned code falls through to BYPASS.
   always_comb begin
      sel_extest = (ir == OP_EXTEST);
      sel_sample = (ir == OP_SAMPLE);
`ifdef TAP_IDCODE_EN
      sel_idcode = (ir == OP_IDCODE);
`else
      sel_idcode = 1'b0;
`endif
      sel_bypass = !(sel_extest || sel_sample || sel_idcode);
   end

`ifdef TAP_IDCODE_EN
   logic [31:0] id_sr;

   // ID register: loads the device ID in Capture-DR and shifts it out
   // LSB-first, only while IDCODE is the active instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                id_sr <= '0;
      else if (sel_idcode && state == CAP_DR) id_sr <= IDCODE_VAL;
      else if (sel_idcode && state == SH_DR)  id_sr <= {tdi, id_sr[31:1]};
   end

   assign id_bit = id_sr[0];
`else
   logic unused_idcode;

   assign unused_idcode = ^IDCODE_VAL;
   assign id_bit        = 1'b0;
`endif

   // Strobes come straight from the registered state, so they are glitch-free.
   always_comb begin
      shift_dr   = (state == SH_DR);
      capture_dr = (state == CAP_DR);
      update_dr  = (state == UPD_DR);
      bp_shift   = shift_dr && sel_bypass;
      bsr_select = sel_extest || sel_sample;
      mode       = sel_extest;
      tdo_en     = (state == SH_DR) || (state == SH_IR);
   end

   // tdo mux: instruction register in Shift-IR, selected data register in
   // Shift-DR, quiet zero everywhere else.
   always_comb begin
      tdo = 1'b0;
      if (state == SH_IR) begin
         tdo = ir_sr[0];
      end else if (state == SH_DR) begin
         if (sel_extest || sel_sample) tdo = bsr_out;
         else if (sel_idcode)          tdo = id_bit;
         else                          tdo = bypass_out;
      end
   end

endmodule

// File: tb/tb_tap_controller.sv
// tb_tap_controller
// Self-checking bench for tap_controller: a table of directed vectors, a few
// hand-written multi-cycle sequences and a long randomized run, all compared
// against a name-based reference model of the TAP (state-name transition
// table, integer arithmetic for the shift registers).
module tb_tap_controller;

   localparam int          W   = 4;
   localparam logic [31:0] IDV = 32'h1000_0001;
`ifdef TAP_IDCODE_EN
   localparam logic [3:0] DEF    = 4'h2;
   localparam bit         DEF_BP = 1'b0;
`else
   localparam logic [3:0] DEF    = 4'hF;
   localparam bit         DEF_BP = 1'b1;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         tms = 1'b1;
   logic         tdi = 1'b0;
   logic         bpoDrv = 1'b0;
   logic         bsr_out = 1'b0;
   logic         bypass_out;
   logic         loopMode = 1'b0;
   logic         bpLoop = 1'b0;
   logic [3:0]   state;
   logic [W-1:0] ir;
   logic         shift_dr, capture_dr, update_dr, bp_shift;
   logic         bsr_select, mode, tdo, tdo_en;

   int compared = 0;
   int mismatched = 0;

   tap_controller #(.IR_WIDTH(W), .IDCODE_VAL(IDV)) dut (
      .clk(clk), .rst(rst), .tms(tms), .tdi(tdi),
      .bypass_out(bypass_out), .bsr_out(bsr_out),
      .state(state), .ir(ir),
      .shift_dr(shift_dr), .capture_dr(capture_dr), .update_dr(update_dr),
      .bp_shift(bp_shift), .bsr_select(bsr_select), .mode(mode),
      .tdo(tdo), .tdo_en(tdo_en)
   );

   always #5 clk = ~clk;

   // External one-stage bypass register used by the loop-through test.
   always @(posedge clk) bpLoop <= tdi;
   assign bypass_out = loopMode ? bpLoop : bpoDrv;

   // Reference model state
   logic [3:0]  enc [string];
   string       nxt0 [string];
   string       nxt1 [string];
   string       mst;
   int          mir;
   int          mirsr;
   logic [31:0] mid;

   typedef struct {
      bit         tms;
      bit         tdi;
      bit         bpo;
      bit         bso;
      logic [3:0] st;
      logic [3:0] ir;
      bit         tdo;
      bit         en;
      bit         md;
      bit         bs;
      bit         bp;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic addState(input string n, input logic [3:0] e, input string z, input string o);
      enc[n]  = e;
      nxt0[n] = z;
      nxt1[n] = o;
   endtask

   task automatic buildModel();
      addState("TLR",     4'hF, "RTI",     "TLR");
      addState("RTI",     4'hC, "RTI",     "SelDR");
      addState("SelDR",   4'h7, "CapDR",   "SelIR");
      addState("CapDR",   4'h6, "ShDR",    "Ex1DR");
      addState("ShDR",    4'h2, "ShDR",    "Ex1DR");
      addState("Ex1DR",   4'h1, "PauseDR", "UpdDR");
      addState("PauseDR", 4'h3, "PauseDR", "Ex2DR");
      addState("Ex2DR",   4'h0, "ShDR",    "UpdDR");
      addState("UpdDR",   4'h5, "RTI",     "SelDR");
      addState("SelIR",   4'h4, "CapIR",   "TLR");
      addState("CapIR",   4'hE, "ShIR",    "Ex1IR");
      addState("ShIR",    4'hA, "ShIR",    "Ex1IR");
      addState("Ex1IR",   4'h9, "PauseIR", "UpdIR");
      addState("PauseIR", 4'hB, "PauseIR", "Ex2IR");
      addState("Ex2IR",   4'h8, "ShIR",    "UpdIR");
      addState("UpdIR",   4'hD, "RTI",     "SelDR");
   endtask

   task automatic modelReset();
      mst   = "TLR";
      mir   = int'(DEF);
      mirsr = 0;
      mid   = '0;
   endtask

   function automatic bit modelIdcode();
`ifdef TAP_IDCODE_EN
      return mir == 2;
`else
      return 1'b0;
`endif
   endfunction

   task automatic modelStep(input bit t, input bit d);
      if (mst == "CapIR")     mirsr = 1;
      else if (mst == "ShIR") mirsr = (mirsr >> 1) | (int'(d) << (W - 1));
      if (mst == "UpdIR")     mir = mirsr;
      else if (mst == "TLR")  mir = int'(DEF);
      if (modelIdcode()) begin
         if (mst == "CapDR")     mid = IDV;
         else if (mst == "ShDR") mid = {d, mid[31:1]};
      end
      mst = t ? nxt1[mst] : nxt0[mst];
   endtask

   // Drive one clock worth of inputs, advance through the rising edge and
   // step the model on that same edge; returns 1 time unit after the edge.
   task automatic applyStimulus(input bit t, input bit d, input bit bpo, input bit bso);
      tms     = t;
      tdi     = d;
      bpoDrv  = bpo;
      bsr_out = bso;
      @(posedge clk);
      modelStep(t, d);
      #1;
   endtask

   task automatic checkOutput();
      bit ext, smp, byp, etdo;
      ext  = (mir == 0);
      smp  = (mir == 1);
      byp  = !(ext || smp || modelIdcode());
      etdo = 1'b0;
      if (mst == "ShIR") etdo = mirsr[0];
      else if (mst == "ShDR") etdo = (ext || smp) ? bsr_out : (byp ? bypass_out : mid[0]);
      check("state",      32'(state),      32'(enc[mst]));
      check("ir",         32'(ir),         32'(mir));
      check("tdo",        32'(tdo),        32'(etdo));
      check("tdo_en",     32'(tdo_en),     32'(mst == "ShDR" || mst == "ShIR"));
      check("shift_dr",   32'(shift_dr),   32'(mst == "ShDR"));
      check("capture_dr", 32'(capture_dr), 32'(mst == "CapDR"));
      check("update_dr",  32'(update_dr),  32'(mst == "UpdDR"));
      check("bp_shift",   32'(bp_shift),   32'(mst == "ShDR" && byp));
      check("bsr_select", 32'(bsr_select), 32'(ext || smp));
      check("mode",       32'(mode),       32'(ext));
   endtask

   task automatic step(input bit t, input bit d);
      applyStimulus(t, d, 1'($urandom), 1'($urandom));
      checkOutput();
   endtask

   // Asynchronous reset: asserted between edges and checked before any clock.
   task automatic doReset();
      #2;
      rst = 1'b1;
      #1;
      check("rst state",    32'(state),    32'hF);
      check("rst ir",       32'(ir),       32'(DEF));
      check("rst tdo_en",   32'(tdo_en),   32'h0);
      check("rst tdo",      32'(tdo),      32'h0);
      check("rst shift_dr", 32'(shift_dr), 32'h0);
      check("rst bp_shift", 32'(bp_shift), 32'h0);
      check("rst mode",     32'(mode),     32'h0);
      check("rst bsr_sel",  32'(bsr_select), 32'h0);
      modelReset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic goIdle();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
      check("five tms=1 reach TLR", 32'(state), 32'hF);
      step(1'b0, 1'b0);
   endtask

   // From RTI: load code through Shift-IR and return to RTI.
   task automatic shiftIr(input logic [W-1:0] code);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      for (int i = 0; i < W; i++) step(i == W - 1, code[i]);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
   endtask

   task automatic addVec(input bit t, input bit d, input bit bpo, input bit bso,
                         input logic [3:0] st, input logic [3:0] eir, input bit etdo,
                         input bit en, input bit md, input bit bs, input bit bp);
      vec_t v;
      v = '{t, d, bpo, bso, st, eir, etdo, en, md, bs, bp};
      vecs.push_back(v);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [7:0] pat;
      bit         prev;

      buildModel();

      // FSM walk 0,1,0,0 then five ones back to TLR
      addVec(0,0,0,0, 4'hC, DEF, 0,0,0,0,0);
      addVec(1,0,0,0, 4'h7, DEF, 0,0,0,0,0);
      addVec(0,0,0,0, 4'h6, DEF, 0,0,0,0,0);
      addVec(0,0,1,0, 4'h2, DEF, 1,1,0,0,DEF_BP);
      addVec(1,0,0,0, 4'h1, DEF, 0,0,0,0,0);
      addVec(1,0,0,0, 4'h5, DEF, 0,0,0,0,0);
      addVec(1,0,0,0, 4'h7, DEF, 0,0,0,0,0);
      addVec(1,0,0,0, 4'h4, DEF, 0,0,0,0,0);
      addVec(1,0,0,0, 4'hF, DEF, 0,0,0,0,0);
      // IR load of EXTEST; captured 0001 appears as 1 then 0 on tdo
      addVec(0,0,0,0, 4'hC, DEF, 0,0,0,0,0);
      addVec(1,0,0,0, 4'h7, DEF, 0,0,0,0,0);
      addVec(1,0,0,0, 4'h4, DEF, 0,0,0,0,0);
      addVec(0,0,0,0, 4'hE, DEF, 0,0,0,0,0);
      addVec(0,0,0,0, 4'hA, DEF, 1,1,0,0,0);
      addVec(0,0,0,0, 4'hA, DEF, 0,1,0,0,0);
      addVec(0,0,0,0, 4'hA, DEF, 0,1,0,0,0);
      addVec(0,0,0,0, 4'hA, DEF, 0,1,0,0,0);
      addVec(1,0,0,0, 4'h9, DEF, 0,0,0,0,0);
      addVec(1,0,0,0, 4'hD, DEF, 0,0,0,0,0);
      addVec(0,0,0,0, 4'hC, 4'h0, 0,0,1,1,0);
      // EXTEST DR scan: tdo follows bsr_out, no bypass shift
      addVec(1,0,0,0, 4'h7, 4'h0, 0,0,1,1,0);
      addVec(0,0,0,0, 4'h6, 4'h0, 0,0,1,1,0);
      addVec(0,0,0,1, 4'h2, 4'h0, 1,1,1,1,0);
      addVec(1,0,1,0, 4'h1, 4'h0, 0,0,1,1,0);
      addVec(1,0,0,0, 4'h5, 4'h0, 0,0,1,1,0);
      addVec(0,0,0,0, 4'hC, 4'h0, 0,0,1,1,0);

      modelReset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      $display("[TB] reset released");
      checkOutput();

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].tms, vecs[i].tdi, vecs[i].bpo, vecs[i].bso);
         check($sformatf("vec%0d state", i),      32'(state),      32'(vecs[i].st));
         check($sformatf("vec%0d ir", i),         32'(ir),         32'(vecs[i].ir));
         check($sformatf("vec%0d tdo", i),        32'(tdo),        32'(vecs[i].tdo));
         check($sformatf("vec%0d tdo_en", i),     32'(tdo_en),     32'(vecs[i].en));
         check($sformatf("vec%0d mode", i),       32'(mode),       32'(vecs[i].md));
         check($sformatf("vec%0d bsr_select", i), 32'(bsr_select), 32'(vecs[i].bs));
         check($sformatf("vec%0d bp_shift", i),   32'(bp_shift),   32'(vecs[i].bp));
         checkOutput();
      end

      // Reset asserted in the middle of Shift-DR
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      doReset();
      step(1'b0, 1'b0);

      // Reset in the middle of an IR shift must not update ir
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      doReset();
      check("ir after aborted shift", 32'(ir), 32'(DEF));
      step(1'b0, 1'b0);

      // Bypass loop-through: tdo is tdi delayed by one clock
      goIdle();
      shiftIr(4'hF);
      loopMode = 1'b1;
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      pat  = 8'b1011_0010;
      prev = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("bypass bp_shift", 32'(bp_shift), 32'h1);
         check("bypass tdo",      32'(tdo),      32'(prev));
         step(i == 7, pat[7 - i]);
         prev = pat[7 - i];
      end
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      loopMode = 1'b0;

      // Unassigned opcode behaves as BYPASS
      shiftIr(4'h5);
      check("illegal ir",       32'(ir),         32'h5);
      check("illegal mode",     32'(mode),       32'h0);
      check("illegal bsr_sel",  32'(bsr_select), 32'h0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      check("illegal bp_shift", 32'(bp_shift),   32'h1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);

`ifdef TAP_IDCODE_EN
      // IDCODE after reset: 32 Shift-DR clocks reproduce the ID LSB-first
      doReset();
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      for (int i = 0; i < 32; i++) begin
         check($sformatf("idcode bit%0d", i), 32'(tdo), 32'(IDV[i]));
         step(i == 31, 1'b0);
      end
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
`endif

      // Randomized run against the model, with occasional async resets
      for (int n = 0; n < 1000; n++) begin
         if ($urandom_range(0, 99) == 0) doReset();
         else step($urandom_range(0, 9) < 4, 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
